main_control_fsm: RTL and testbench

- Multicycle MIPS main control unit; the producer side of the OpALU interface that the ALU control decoder consumes.
- Sequences fetch, decode, execute, memory and writeback steps per instruction from the 6-bit opcode.
- Drives datapath enables, mux selects and the 2-bit ALU operation class.
- Stalls on a memory-ready handshake.

---
 rtl/main_control_pkg.sv | 34 +++
 rtl/main_control_fsm.sv | 146 ++++++++++++++
 tb/tb_main_control_fsm.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/main_control_pkg.sv
// main_control_pkg: shared definitions for the multicycle MIPS main control.
//   state_t   - 4-bit state encoding (also exported on the debug 'state' port)
//   OP_*      - supported instruction[31:26] opcodes
//   ALUOP_*   - OpALU class codes consumed by the ALU control decoder
package main_control_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS main control (Moore FSM).
//   clk, reset (async, active-high)   - clock / reset to S_RESET
//   opcode                            - IR[31:26], looked at in DECODE and MEM_ADDR
//   mem_ready                         - memory finishes the current access
//   PCWrite..OpALU                    - datapath enables, mux selects, ALU class
//   illegal_op                        - DECODE-cycle pulse for unsupported opcodes
//   state                             - current state (debug)
// Outputs depend on state only, except the FETCH stall gating (mem_ready)
// and illegal_op (opcode in DECODE).
module main_control_fsm
  import main_control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] OpALU,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur, nxt;
  logic   mem_ok;

  // With waiting disabled the memory is assumed to always complete in one cycle.
  assign mem_ok = !MEM_WAIT_EN || mem_ready;
  assign state  = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_RESET;
    else       cur <= nxt;
  end

  always_comb begin
    nxt         = cur;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    OpALU       = ALUOP_ADD;
    illegal_op  = 1'b0;
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC only latch once the fetch actually completes.
        IRWrite = mem_ok;
        PCWrite = mem_ok;
        nxt     = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Only an explicit sw goes to a write; anything else falls back to
        // the harmless read path.
        nxt     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = mem_ok ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        nxt      = mem_ok ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        OpALU   = ALUOP_FUNCT;
        nxt     = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        OpALU       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        nxt         = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        nxt      = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      // Encodings 13-15: outputs stay at defaults, recover via FETCH.
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: table-driven check of main_control_fsm.
// Each row gives inputs for one cycle plus the state and packed outputs
// expected in that cycle; a hand-written sequence covers reset mid-EXECUTE.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, OpALU;
  logic [3:0] state;

  main_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .OpALU(OpALU), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
  //  ALUSrcB,PCSource,OpALU,illegal_op}
  logic [16:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, OpALU, illegal_op};

  localparam logic [16:0] O_ZERO  = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] O_FETCH = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] O_FSTL  = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] O_DEC   = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] O_DILL  = 17'b0000000000_11_00_00_1;
  localparam logic [16:0] O_MADDR = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] O_MRD   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] O_MWB   = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] O_MWR   = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] O_EXEC  = 17'b0000000001_00_00_10_0;
  localparam logic [16:0] O_RWB   = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] O_BR    = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] O_JMP   = 17'b1000000000_00_10_00_0;
  localparam logic [16:0] O_AEX   = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] O_AWB   = 17'b0000000010_00_00_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000, IL = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [16:0] out);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.st = st; v.out = out;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [16:0] a,
                     input logic [16:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got %b expected %b", name, idx, a, e);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] st,
                         input logic [16:0] out);
    chk({tag, "_state"}, idx, {13'd0, state}, {13'd0, st});
    chk({tag, "_out"}, idx, act, out);
    chk({tag, "_rdwr_excl"}, idx, {16'd0, MemRead & MemWrite}, 17'd0);
  endtask

  initial begin
    bit found;
    // reset, release
    add(1, RT, 1, 0, O_ZERO);   add(0, RT, 1, 0, O_ZERO);
    // lw: 1,2,3,4,5
    add(0, LW, 1, 1, O_FETCH);  add(0, LW, 1, 2, O_DEC);   add(0, LW, 1, 3, O_MADDR);
    add(0, LW, 1, 4, O_MRD);    add(0, LW, 1, 5, O_MWB);
    // sw, two wait cycles in MEM_WRITE
    add(0, SW, 1, 1, O_FETCH);  add(0, SW, 1, 2, O_DEC);   add(0, SW, 1, 3, O_MADDR);
    add(0, SW, 0, 6, O_MWR);    add(0, SW, 0, 6, O_MWR);   add(0, SW, 1, 6, O_MWR);
    // R-type
    add(0, RT, 1, 1, O_FETCH);  add(0, RT, 1, 2, O_DEC);   add(0, RT, 1, 7, O_EXEC);
    add(0, RT, 1, 8, O_RWB);
    // beq, j
    add(0, BQ, 1, 1, O_FETCH);  add(0, BQ, 1, 2, O_DEC);   add(0, BQ, 1, 9, O_BR);
    add(0, JP, 1, 1, O_FETCH);  add(0, JP, 1, 2, O_DEC);   add(0, JP, 1, 10, O_JMP);
    // addi
    add(0, AD, 1, 1, O_FETCH);  add(0, AD, 1, 2, O_DEC);   add(0, AD, 1, 11, O_AEX);
    add(0, AD, 1, 12, O_AWB);
    // illegal opcode, then a stalled fetch
    add(0, IL, 1, 1, O_FETCH);  add(0, IL, 1, 2, O_DILL);
    add(0, IL, 0, 1, O_FSTL);   add(0, IL, 0, 1, O_FSTL);  add(0, RT, 1, 1, O_FETCH);
    // R-type with opcode changing after DECODE (ignored)
    add(0, RT, 1, 2, O_DEC);    add(0, RT, 1, 7, O_EXEC);  add(0, IL, 1, 8, O_RWB);
    // lw with one wait cycle in MEM_READ
    add(0, LW, 1, 1, O_FETCH);  add(0, LW, 1, 2, O_DEC);   add(0, LW, 1, 3, O_MADDR);
    add(0, LW, 0, 4, O_MRD);    add(0, LW, 1, 4, O_MRD);   add(0, LW, 1, 5, O_MWB);
    add(0, RT, 1, 1, O_FETCH);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].mr;
      @(negedge clk);
      chk_all("vec", i, tbl[i].st, tbl[i].out);
      @(posedge clk); #1;
    end

    // reset held 3 cycles mid-EXECUTE
    opcode = RT; mem_ready = 1'b1; found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (state == 4'd7) found = 1'b1;
    end
    chk("reach_execute", 0, {16'd0, found}, 17'd1);
    reset = 1'b1; #1;
    chk_all("rst_async", 0, 4'd0, O_ZERO);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_all("rst_hold", k, 4'd0, O_ZERO);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_all("rst_rel", 0, 4'd0, O_ZERO);
    @(posedge clk); #1;
    chk_all("rst_fetch", 0, 4'd1, O_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
